// File: rtl/fix_output_buffer_pkg.sv
// Shared types and helpers for the filter output buffer.
package fix_output_buffer_pkg;

    localparam int unsigned SAMPLE_W = 14;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        HAS_DATA = 2'd1,
        FULL     = 2'd2
    } buf_state_t;

    // Offset binary to two's complement: flip the MSB of a width-bit word.
    function automatic logic [31:0] to_signed(input logic [31:0] word, input int unsigned width);
        return word ^ (32'(1) << (width - 1));
    endfunction

endpackage

// File: rtl/fix_output_buffer_sync_fifo.sv
// Synchronous FIFO with an explicit occupancy counter; pointers wrap modulo DEPTH.
module fix_output_buffer_sync_fifo #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage is reset so the head word reads 0 straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);

endmodule

// File: rtl/fix_output_buffer.sv
// Captures decimated filter words on the sample-clock edge, buffers them and
// streams them out on valid/ready while accounting for back-pressure drops.
module fix_output_buffer
    import fix_output_buffer_pkg::*;
#(
    parameter int unsigned WIDTH      = SAMPLE_W,
    parameter int unsigned DEPTH      = 16,
    parameter bit          SIGNED_OUT = 1'b1,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_clk,
    input  logic                     sample_valid,
    input  logic [WIDTH-1:0]         sample_data,
    input  logic                     flush,
    output logic [WIDTH-1:0]         m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    buf_state_t       state;
    buf_state_t       state_n;
    logic             sample_clk_q;
    logic             cap;
    logic             pop;
    logic             push;
    logic             drop;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] fmt_data;

    assign cap  = sample_clk & ~sample_clk_q & sample_valid;
    assign pop  = m_valid & m_ready & ~empty;
    assign push = cap & (~full | pop);
    assign drop = cap & full & ~pop;

    generate
        if (SIGNED_OUT) begin : g_signed
            assign fmt_data = WIDTH'(to_signed(32'(sample_data), WIDTH));
        end else begin : g_raw
            assign fmt_data = sample_data;
        end
    endgenerate

    fix_output_buffer_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear   (flush),
        .wr_en   (push & ~flush),
        .wr_data (fmt_data),
        .rd_en   (pop & ~flush),
        .rd_data (m_data),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_clk_q <= 1'b0;
            state        <= EMPTY;
            m_valid      <= 1'b0;
        end else begin
            sample_clk_q <= sample_clk;
            state        <= state_n;
            m_valid      <= (state_n != EMPTY);
        end
    end

    // Stream-side occupancy state; flush overrides any push/pop this cycle.
    always_comb begin
        state_n = state;
        if (flush) begin
            state_n = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) state_n = HAS_DATA;
                end
                HAS_DATA: begin
                    if (pop && !push && level == LVL_W'(1)) begin
                        state_n = EMPTY;
                    end else if (push && !pop && level == LVL_W'(DEPTH - 1)) begin
                        state_n = FULL;
                    end
                end
                FULL: begin
                    if (pop && !push) state_n = HAS_DATA;
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (flush) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != {CNT_W{1'b1}}) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fix_output_buffer.sv
// Scoreboard bench for fix_output_buffer: stimulus queues expected words,
// a negedge monitor checks every accepted output word.
module tb_fix_output_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_clk = 1'b0;
    logic        sample_valid = 1'b0;
    logic [13:0] sample_data = '0;
    logic        flush = 1'b0;
    logic        m_ready = 1'b0;

    logic [13:0] m_data;
    logic        m_valid;
    logic [4:0]  level;
    logic        overflow;
    logic [7:0]  drop_count;

    logic [13:0] r_data;
    logic        r_valid;
    logic [4:0]  r_level;
    logic        r_overflow;
    logic [7:0]  r_drop_count;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [13:0] exp_q[$];
    logic        mv;
    logic [13:0] rd;

    always #5 clk = ~clk;

    fix_output_buffer #(
        .WIDTH(14), .DEPTH(16), .SIGNED_OUT(1'b1), .CNT_W(8)
    ) u_dut (
        .clk(clk), .rst(rst), .sample_clk(sample_clk), .sample_valid(sample_valid),
        .sample_data(sample_data), .flush(flush), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .level(level), .overflow(overflow), .drop_count(drop_count)
    );

    fix_output_buffer #(
        .WIDTH(14), .DEPTH(16), .SIGNED_OUT(1'b0), .CNT_W(8)
    ) u_raw (
        .clk(clk), .rst(rst), .sample_clk(sample_clk), .sample_valid(sample_valid),
        .sample_data(sample_data), .flush(flush), .m_data(r_data), .m_valid(r_valid),
        .m_ready(m_ready), .level(r_level), .overflow(r_overflow), .drop_count(r_drop_count)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: a word is accepted at the next posedge when valid & ready.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_word: got 0x%0h expected none", m_data);
            end else begin
                check("m_data", 32'(m_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 12-clk sample period; capture happens on the first edge.
    task automatic period(input logic [13:0] d, input logic v, input logic pulse,
                          output logic cap_mv, output logic [13:0] cap_raw);
        sample_data  = d;
        sample_valid = v;
        sample_clk   = 1'b1;
        if (pulse) m_ready = 1'b1;
        tick();
        cap_mv  = m_valid;
        cap_raw = r_data;
        if (pulse) m_ready = 1'b0;
        repeat (5) tick();
        sample_clk = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Steady stream: 0x2000+i emerges as i, one clk after capture.
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(14'(i));
            period(14'h2000 + 14'(i), 1'b1, 1'b0, mv, rd);
            check("first_word_latency", 32'(mv), 32'd1);
        end
        check("steady_overflow", 32'(overflow), 32'd0);
        check("steady_level", 32'(level), 32'd0);

        // Gated: sample_valid low means no pushes.
        for (int i = 0; i < 5; i++) period(14'h1234, 1'b0, 1'b0, mv, rd);
        check("gated_level", 32'(level), 32'd0);
        check("gated_m_valid", 32'(m_valid), 32'd0);

        // Back-pressure: 20 captures into 16 entries.
        m_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i < 16) exp_q.push_back(14'h0100 + 14'(i));
            period(14'h2100 + 14'(i), 1'b1, 1'b0, mv, rd);
        end
        check("bp_level", 32'(level), 32'd16);
        check("bp_overflow", 32'(overflow), 32'd1);
        check("bp_drop_count", 32'(drop_count), 32'd4);
        check("bp_head_stable", 32'(m_data), 32'h0100);

        // Full with capture and pop together: both accepted, no drop.
        exp_q.push_back(14'h1001);
        period(14'h3001, 1'b1, 1'b1, mv, rd);
        check("full_cap_pop_level", 32'(level), 32'd16);
        check("full_cap_pop_drops", 32'(drop_count), 32'd4);

        // Saturation of the drop counter.
        for (int i = 0; i < 300; i++) period(14'h3fff, 1'b1, 1'b0, mv, rd);
        check("sat_drop_count", 32'(drop_count), 32'd255);
        for (int i = 0; i < 3; i++) period(14'h3ffe, 1'b1, 1'b0, mv, rd);
        check("sat_hold", 32'(drop_count), 32'd255);
        check("sat_level", 32'(level), 32'd16);

        // Drain with bounded wait; monitor checks order.
        m_ready = 1'b1;
        for (int i = 0; i < 100 && level != 0; i++) tick();
        check("drain_level", 32'(level), 32'd0);
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);

        // Flush at level 9 with a capture in the same cycle.
        m_ready = 1'b0;
        for (int i = 0; i < 9; i++) period(14'h2200 + 14'(i), 1'b1, 1'b0, mv, rd);
        check("pre_flush_level", 32'(level), 32'd9);
        sample_data  = 14'h2555;
        sample_valid = 1'b1;
        sample_clk   = 1'b1;
        flush        = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_level", 32'(level), 32'd0);
        check("flush_m_valid", 32'(m_valid), 32'd0);
        check("flush_overflow", 32'(overflow), 32'd0);
        check("flush_drop_count", 32'(drop_count), 32'd0);
        repeat (5) tick();
        sample_clk = 1'b0;
        repeat (6) tick();
        check("flush_cap_lost", 32'(level), 32'd0);
        m_ready = 1'b1;
        repeat (4) tick();

        // Format: signed flips MSB, raw passes offset binary.
        exp_q.push_back(14'h0abc);
        period(14'h2abc, 1'b1, 1'b0, mv, rd);
        check("raw_passthrough", 32'(rd), 32'h2abc);
        check("fmt_queue_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-burst.
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) period(14'h3333, 1'b1, 1'b0, mv, rd);
        sample_clk = 1'b1;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_m_valid", 32'(m_valid), 32'd0);
        check("arst_m_data", 32'(m_data), 32'd0);
        check("arst_level", 32'(level), 32'd0);
        check("arst_drop_count", 32'(drop_count), 32'd0);
        check("arst_overflow", 32'(overflow), 32'd0);
        tick();
        sample_clk = 1'b0;
        rst = 1'b0;
        repeat (3) tick();
        check("post_rst_level", 32'(level), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
